sd_cmd_phy: RTL and testbench

- Physical-layer stage of the CMD path, directly downstream of the CMD control block.
- Takes the 40-bit command frame body from the control stage. Appends CRC7 and the end bit, then shifts the 48-bit frame MSB-first onto the SD CMD line.
- Waits for and deserialises the card response, then returns it to the control stage over the strobe/ack handshake.
- Flags timeout and response CRC errors.

---
 rtl/sd_cmd_pkg.sv | 33 +++
 rtl/sd_crc7.sv | 19 +
 rtl/sd_cmd_phy.sv | 168 ++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared encodings for the SD CMD physical layer: FSM states, response types, frame lengths, CRC7.
// No logic of its own; imported by sd_crc7 and sd_cmd_phy.
// Backpressure: not applicable.
package sd_cmd_pkg;

  // One-hot FSM state encodings
  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_SEND = 5'b00010;
  localparam logic [4:0] ST_WAIT = 5'b00100;
  localparam logic [4:0] ST_RECV = 5'b01000;
  localparam logic [4:0] ST_DONE = 5'b10000;

  // Response type codes; 11 behaves like a short response
  localparam logic [1:0] RESP_NONE  = 2'b00;
  localparam logic [1:0] RESP_SHORT = 2'b01;
  localparam logic [1:0] RESP_LONG  = 2'b10;
  localparam logic [1:0] RESP_ALT   = 2'b11;

  // Frame lengths in bits
  localparam int TX_LEN    = 48;
  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;
  localparam int BODY_LEN  = 40;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial CRC7 step, MSB-first input
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    crc7_step = {crc[5:0], 1'b0} ^ (((crc[6] ^ b) == 1'b1) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: clear to zero, then absorb one bit per enabled cycle.
// Latency: result reflects a bit one cycle after it is presented with enable high.
// Backpressure: none; the caller gates enable.
module sd_crc7 import sd_cmd_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  // Clear has priority over accumulation
  always_ff @(posedge clock) begin
    if (!reset || clear) crc <= '0;
    else if (enable)     crc <= crc7_step(crc, bit_in);
  end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD line PHY: serialises a 40-bit command plus CRC7/end bit, then captures the card response.
// Latency: 48 bit cycles of TX, then wait (bounded by TIMEOUT_CYCLES) and 48/136 bit cycles of RX.
// Backpressure: result held on strobe_out until ack_in; a new request needs strobe_in low in IDLE.
// Optional: define SD_CMD_PHY_CRC_CHECK_EN to build the response CRC7 checker (else crc_error=0).
module sd_cmd_phy import sd_cmd_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         strobe_in,
  input  logic         ack_in,
  input  logic         idle_in,
  input  logic [39:0]  cmd_frame,
  input  logic [1:0]   resp_type,
  input  logic         timeout_enable,
  input  logic         crc_check,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_oe,
  output logic         ack_out,
  output logic         strobe_out,
  output logic [127:0] cmd_response,
  output logic         time_out,
  output logic         crc_error
);

  logic [4:0]       state;
  logic [39:0]      tx_sh;
  logic [1:0]       resp_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] rx_len;
  // Received bits excluding the end bit; rx_sh[i] ends up holding frame bit i+1
  logic [126:0]     rx_sh;
  logic             armed;
  logic [6:0]       tx_crc;
  logic [2:0]       crc_idx;
  logic             is_short;
  logic             is_long;
  logic             tx_feed;
  logic             start_bit;
  logic             rx_last;
  logic             crc_mismatch;

  assign is_long   = (resp_q == RESP_LONG);
  assign is_short  = (resp_q == RESP_SHORT) || (resp_q == RESP_ALT);
  assign rx_len    = is_long ? CNT_W'(LONG_LEN) : CNT_W'(SHORT_LEN);
  assign tx_feed   = (state == ST_SEND) && (bit_cnt < CNT_W'(BODY_LEN));
  assign start_bit = (state == ST_WAIT) && !cmd_pin_in;
  assign rx_last   = (state == ST_RECV) && (bit_cnt == rx_len - 1'b1);
  assign crc_idx   = 3'(CNT_W'(TX_LEN - 2) - bit_cnt);

  sd_crc7 u_tx_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == ST_IDLE),
    .enable (tx_feed),
    .bit_in (tx_sh[39]),
    .crc    (tx_crc)
  );

`ifdef SD_CMD_PHY_CRC_CHECK_EN
  logic [6:0] rx_crc;

  // The start bit is absorbed on the WAIT->RECV edge, then bits 1..39 in RECV
  sd_crc7 u_rx_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (!((state == ST_RECV) || start_bit)),
    .enable (start_bit || ((state == ST_RECV) && (bit_cnt < CNT_W'(BODY_LEN)))),
    .bit_in (cmd_pin_in),
    .crc    (rx_crc)
  );

  assign crc_mismatch = crc_check && is_short && (rx_crc != rx_sh[6:0]);
`else
  logic unused_crc_check;
  assign unused_crc_check = crc_check;
  assign crc_mismatch     = 1'b0;
`endif

  assign cmd_oe     = (state == ST_SEND);
  assign ack_out    = (state == ST_SEND) && (bit_cnt == '0);
  assign strobe_out = (state == ST_DONE);

  // Line value: command body, then the held TX CRC, then the end bit; released high otherwise
  always_comb begin
    cmd_pin_out = 1'b1;
    if (state == ST_SEND) begin
      if (bit_cnt < CNT_W'(BODY_LEN))        cmd_pin_out = tx_sh[39];
      else if (bit_cnt < CNT_W'(TX_LEN - 1)) cmd_pin_out = tx_crc[crc_idx];
    end
  end

  // Transaction FSM; abort beats every other request, cmd_response survives it
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      tx_sh        <= '0;
      resp_q       <= RESP_NONE;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      rx_sh        <= '0;
      armed        <= 1'b0;
      cmd_response <= '0;
      time_out     <= 1'b0;
      crc_error    <= 1'b0;
    end else if (idle_in) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!strobe_in) begin
            armed <= 1'b1;
          end else if (armed) begin
            tx_sh     <= cmd_frame;
            resp_q    <= resp_type;
            time_out  <= 1'b0;
            crc_error <= 1'b0;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          tx_sh <= {tx_sh[38:0], 1'b0};
          if (bit_cnt == CNT_W'(TX_LEN - 1)) begin
            bit_cnt <= '0;
            state   <= (resp_q == RESP_NONE) ? ST_DONE : ST_WAIT;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (!cmd_pin_in) begin
            rx_sh   <= '0;
            bit_cnt <= CNT_W'(1);
            state   <= ST_RECV;
          end else if (timeout_enable && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            time_out <= 1'b1;
            state    <= ST_DONE;
          end else if (tmo_cnt < CNT_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RECV: begin
          if (rx_last) begin
            cmd_response <= is_long ? {1'b0, rx_sh} : {90'b0, rx_sh[44:7]};
            crc_error    <= crc_mismatch;
            state        <= ST_DONE;
          end else begin
            rx_sh   <= {rx_sh[125:0], cmd_pin_in};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (ack_in) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Scoreboard bench for sd_cmd_phy: stimulus pushes expected frames/results, a monitor pops and compares.
// The card side is emulated by the stimulus thread; CRC7 is modelled as polynomial long division.
// Build with or without SD_CMD_PHY_CRC_CHECK_EN; the expected crc_error follows the macro.
module tb_sd_cmd_phy;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         strobe_in = 1'b0;
  logic         ack_in = 1'b0;
  logic         idle_in = 1'b0;
  logic [39:0]  cmd_frame = '0;
  logic [1:0]   resp_type = '0;
  logic         timeout_enable = 1'b0;
  logic         crc_check = 1'b0;
  logic         cmd_pin_in = 1'b1;
  logic         cmd_pin_out;
  logic         cmd_oe;
  logic         ack_out;
  logic         strobe_out;
  logic [127:0] cmd_response;
  logic         time_out;
  logic         crc_error;

  sd_cmd_phy dut (
    .clock          (clock),
    .reset          (reset),
    .strobe_in      (strobe_in),
    .ack_in         (ack_in),
    .idle_in        (idle_in),
    .cmd_frame      (cmd_frame),
    .resp_type      (resp_type),
    .timeout_enable (timeout_enable),
    .crc_check      (crc_check),
    .cmd_pin_in     (cmd_pin_in),
    .cmd_pin_out    (cmd_pin_out),
    .cmd_oe         (cmd_oe),
    .ack_out        (ack_out),
    .strobe_out     (strobe_out),
    .cmd_response   (cmd_response),
    .time_out       (time_out),
    .crc_error      (crc_error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1; message is bits[n-1:0], MSB first
  function automatic logic [6:0] ref_crc7(input logic [135:0] bits, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = n - 1; i >= -7; i--) begin
      r = {r[6:0], (i >= 0) ? bits[i] : 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  typedef struct {
    logic [47:0]  tx;
    logic [127:0] resp;
    logic         to;
    logic         ce;
    int           delta;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] last_resp = '0;
  bit           mon_skip = 1'b0;

  int          cyc = 0;
  int          ack_cnt = 0;
  int          tx_n = 0;
  int          fall_cyc = 0;
  logic [47:0] tx_word = '0;
  logic        prev_oe = 1'b0;
  logic        prev_stb = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: collect line bits while driven, compare on release and on result strobe
  always @(negedge clock) begin
    exp_t e;
    if (ack_out) ack_cnt++;
    if (cmd_oe) begin
      if (tx_n == 0) check("ack_on_first_bit", 128'(ack_out), 128'd1);
      tx_word = {tx_word[46:0], cmd_pin_out};
      tx_n++;
    end
    if (prev_oe && !cmd_oe) begin
      fall_cyc = cyc;
      if (!mon_skip) begin
        if (exp_q.size() == 0) bound_fail("tx_without_expectation");
        else begin
          check("tx_len", 128'(tx_n), 128'd48);
          check("tx_frame", 128'(tx_word), 128'(exp_q[0].tx));
        end
      end
      tx_n = 0;
    end
    if (strobe_out && !prev_stb && !mon_skip) begin
      if (exp_q.size() == 0) bound_fail("strobe_without_expectation");
      else begin
        e = exp_q.pop_front();
        check("response", cmd_response, e.resp);
        check("time_out", 128'(time_out), 128'(e.to));
        check("crc_error", 128'(crc_error), 128'(e.ce));
        check("strobe_latency", 128'(cyc - fall_cyc), 128'(e.delta));
      end
    end
    prev_oe  = cmd_oe;
    prev_stb = strobe_out;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue a request and wait for ack_out; returns with strobe_in still high
  task automatic issue(input logic [39:0] frame, input logic [1:0] rt, input logic ten, input logic cchk);
    bit got;
    step();
    cmd_frame = frame; resp_type = rt; timeout_enable = ten; crc_check = cchk; strobe_in = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (ack_out) got = 1;
    end
    if (!got) bound_fail("ack_wait");
  endtask

  task automatic wait_oe_fall();
    bit got;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (!cmd_oe) got = 1;
      else step();
    end
    if (!got) bound_fail("oe_fall_wait");
  endtask

  task automatic run_txn(input logic [39:0] frame, input logic [1:0] rt, input logic ten,
                         input logic cchk, input int delay, input logic [135:0] card,
                         input bit flip, input bit hold_strobe);
    exp_t         e;
    int           len;
    int           a0;
    int           hold;
    bit           silent;
    bit           got;
    logic [135:0] cf;
    len = (rt == 2'b10) ? 136 : 48;
    cf = card;
    if (flip) cf[8] = ~cf[8];
    silent = (rt != 2'b00) && ten && (delay >= 64);
    e.tx = {frame, ref_crc7({96'b0, frame}, 40), 1'b1};
    e.to = 1'b0; e.ce = 1'b0; e.resp = last_resp;
    if (rt == 2'b00) e.delta = 0;
    else if (silent) begin e.to = 1'b1; e.delta = 64; end
    else begin
      e.delta = delay + len;
      if (rt == 2'b10) e.resp = {1'b0, cf[127:1]};
      else begin
        e.resp = {90'b0, cf[45:8]};
`ifdef SD_CMD_PHY_CRC_CHECK_EN
        e.ce = cchk && (ref_crc7({96'b0, cf[47:8]}, 40) != cf[7:1]);
`endif
      end
    end
    last_resp = e.resp;
    exp_q.push_back(e);
    a0 = ack_cnt;
    issue(frame, rt, ten, cchk);
    if (!hold_strobe) strobe_in = 1'b0;
    cmd_frame = {8'($urandom), $urandom};
    wait_oe_fall();
    if (rt != 2'b00 && !silent) begin
      repeat (delay) step();
      for (int k = len - 1; k >= 0; k--) begin
        cmd_pin_in = cf[k];
        step();
      end
      cmd_pin_in = 1'b1;
    end
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (strobe_out) got = 1;
      else step();
    end
    if (!got) bound_fail("strobe_wait");
    hold = $urandom_range(0, 3);
    repeat (hold) step();
    check("strobe_held", 128'(strobe_out), 128'd1);
    check("resp_held", cmd_response, e.resp);
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    check("strobe_drop", 128'(strobe_out), 128'd0);
    if (hold_strobe) begin
      repeat (8) step();
      check("no_retrigger", 128'({cmd_oe, strobe_out}), 128'd0);
      strobe_in = 1'b0;
    end
    check("ack_pulses", 128'(ack_cnt - a0), 128'd1);
  endtask

  function automatic logic [135:0] short_card(input logic [5:0] idx, input logic [31:0] status);
    logic [39:0] hdr;
    hdr = {2'b00, idx, status};
    return {88'b0, hdr, ref_crc7({96'b0, hdr}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] long_card(input logic [126:0] payload);
    return {8'h3F, payload, 1'b1};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_pin_out"}, 128'(cmd_pin_out), 128'd1);
    check({tag, "_oe"}, 128'(cmd_oe), 128'd0);
    check({tag, "_ack_out"}, 128'(ack_out), 128'd0);
    check({tag, "_strobe_out"}, 128'(strobe_out), 128'd0);
    check({tag, "_response"}, cmd_response, 128'd0);
    check({tag, "_time_out"}, 128'(time_out), 128'd0);
    check({tag, "_crc_error"}, 128'(crc_error), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [126:0] pl;
    logic [1:0]   rt;
    logic [135:0] cd;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b1;
    repeat (2) step();

    // CMD0, no response
    run_txn(40'h4000000000, 2'b00, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    // CMD8 short response after 5 idle cycles, good and corrupted CRC
    run_txn(40'h48000001AA, 2'b01, 1'b1, 1'b1, 5, 136'h08000001AA13, 1'b0, 1'b0);
    run_txn(40'h48000001AA, 2'b01, 1'b1, 1'b1, 5, 136'h08000001AA13, 1'b1, 1'b0);
    // CMD17 with a silent card
    run_txn(40'h5100000000, 2'b01, 1'b1, 1'b1, 64, '0, 1'b0, 1'b0);
    // Long response, payload ending in A5
    pl = {$urandom, $urandom, $urandom, $urandom};
    pl[7:0] = 8'hA5;
    run_txn(40'h4200000000, 2'b10, 1'b1, 1'b0, 3, long_card(pl), 1'b0, 1'b0);
    // Start bit on the last allowed cycle, and no timeout with enable low
    run_txn(40'h4D12345678, 2'b01, 1'b1, 1'b1, 63, short_card(6'd13, 32'hCAFE0001), 1'b0, 1'b0);
    run_txn(40'h4D12345678, 2'b01, 1'b0, 1'b1, 100, short_card(6'd13, 32'h00000900), 1'b0, 1'b0);
    // Type 11 behaves as short; crc_check=0 masks a bad CRC
    run_txn(40'h6900FF8000, 2'b11, 1'b1, 1'b0, 2, short_card(6'd63, 32'h00FF8000), 1'b1, 1'b0);
    // strobe_in held high through the whole transaction must not retrigger
    run_txn(40'h4D00010000, 2'b01, 1'b1, 1'b1, 1, short_card(6'd13, 32'h00000700), 1'b0, 1'b1);

    // Abort at frame bit 20
    mon_skip = 1'b1;
    issue({2'b01, 6'd17, $urandom}, 2'b01, 1'b1, 1'b1);
    strobe_in = 1'b0;
    repeat (20) step();
    check("abort_pre_oe", 128'(cmd_oe), 128'd1);
    idle_in = 1'b1;
    step();
    idle_in = 1'b0;
    check("abort_oe", 128'(cmd_oe), 128'd0);
    check("abort_strobe", 128'(strobe_out), 128'd0);
    check("abort_keeps_resp", cmd_response, last_resp);
    repeat (3) step();
    mon_skip = 1'b0;
    run_txn(40'h4000000000, 2'b00, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);

    // Reset while receiving
    mon_skip = 1'b1;
    issue({2'b01, 6'd8, $urandom}, 2'b01, 1'b1, 1'b1);
    strobe_in = 1'b0;
    wait_oe_fall();
    cmd_pin_in = 1'b0;
    repeat (10) begin
      step();
      cmd_pin_in = 1'($urandom);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    cmd_pin_in = 1'b1;
    check_reset_values("mid_rx_reset");
    last_resp = '0;
    repeat (3) step();
    mon_skip = 1'b0;

    // Randomised transactions
    for (int n = 0; n < 12; n++) begin
      rt = 2'($urandom_range(0, 3));
      if (rt == 2'b10) begin
        pl = {$urandom, $urandom, $urandom, $urandom};
        cd = long_card(pl);
      end else begin
        cd = short_card(6'($urandom), $urandom);
      end
      run_txn({2'b01, 6'($urandom), $urandom}, rt, 1'($urandom), 1'($urandom),
              $urandom_range(0, 70), cd, 1'($urandom_range(0, 2) == 0), 1'b0);
    end

    repeat (5) step();
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
